mlcd_8080_ctrl: RTL and testbench

//  Hardware 8080-style MCU LCD bus master that replaces the per-pin PIO bit-banging of cs_n/wr_n/rd_n/rs/data.

---
 rtl/mlcd_8080_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mlcd_8080_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlcd_8080_ctrl.sv
// rtl/mlcd_8080_ctrl.sv - 8080-style MCU LCD bus master with request FIFO and programmable strobe timing
module mlcd_8080_ctrl #(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 17,
    parameter int WR_LOW     = 2,
    parameter int WR_HIGH    = 2,
    parameter int RD_LOW     = 5,
    parameter int RD_HIGH    = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_type,
    input  logic [DW-1:0]    req_data,
    input  logic [LEN_W-1:0] req_len,
    output logic             rd_valid,
    output logic [DW-1:0]    rd_data,
    output logic             busy,
    output logic             mlcd_cs_n,
    output logic             mlcd_wr_n,
    output logic             mlcd_rd_n,
    output logic             mlcd_rs,
    output logic [DW-1:0]    mlcd_data_o,
    output logic             mlcd_data_oe,
    input  logic [DW-1:0]    mlcd_data_i
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 2 + DW + LEN_W;
    localparam logic [AW:0] FIFO_FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  WR_LO_LAST = 8'(WR_LOW - 1);
    localparam logic [7:0]  WR_HI_LAST = 8'(WR_HIGH - 1);
    localparam logic [7:0]  RD_LO_LAST = 8'(RD_LOW - 1);
    localparam logic [7:0]  RD_HI_LAST = 8'(RD_HIGH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WR_LO, S_WR_HI, S_RD_LO, S_RD_HI
    } state_t;

    state_t            state, state_d;
    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       fifo_cnt;
    logic              fifo_full, fifo_empty, push, pop, rst_done;
    logic [7:0]        phase_cnt;
    logic [LEN_W-1:0]  beats;
    logic [1:0]        cur_type;
    logic [DW-1:0]     cur_data;
    logic [LEN_W-1:0]  cur_len;

    assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign req_ready  = rst_done && !fifo_full;
    assign push       = req_valid && req_ready;
    assign busy       = !fifo_empty || (state != S_IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_done <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            rst_done <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[wr_ptr] <= {req_type, req_data, req_len};
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cur_type == 2'b10) begin
                    state_d = S_RD_LO;
                end else if (cur_type == 2'b11 && cur_len == '0) begin
                    pop     = !fifo_empty;
                    state_d = fifo_empty ? S_IDLE : S_SETUP;
                end else begin
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: if (phase_cnt == WR_LO_LAST) state_d = S_WR_HI;
            S_WR_HI: begin
                if (phase_cnt == WR_HI_LAST) begin
                    if (beats > LEN_W'(1)) begin
                        state_d = S_WR_LO;
                    end else begin
                        pop     = !fifo_empty;
                        state_d = fifo_empty ? S_IDLE : S_SETUP;
                    end
                end
            end
            S_RD_LO: if (phase_cnt == RD_LO_LAST) state_d = S_RD_HI;
            S_RD_HI: begin
                if (phase_cnt == RD_HI_LAST) begin
                    pop     = !fifo_empty;
                    state_d = fifo_empty ? S_IDLE : S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            beats     <= '0;
            cur_type  <= '0;
            cur_data  <= '0;
            cur_len   <= '0;
        end else begin
            state     <= state_d;
            phase_cnt <= (state_d == state) ? phase_cnt + 8'd1 : 8'd0;
            if (pop) {cur_type, cur_data, cur_len} <= fifo_mem[rd_ptr];
            if (state == S_SETUP)
                beats <= (cur_type == 2'b11) ? cur_len : LEN_W'(1);
            else if (state == S_WR_HI && state_d == S_WR_LO)
                beats <= beats - LEN_W'(1);
        end
    end

    // Pads are a registered decode of the current state, so every strobe lags the FSM by one clean cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mlcd_cs_n    <= 1'b1;
            mlcd_wr_n    <= 1'b1;
            mlcd_rd_n    <= 1'b1;
            mlcd_rs      <= 1'b0;
            mlcd_data_o  <= '0;
            mlcd_data_oe <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    mlcd_cs_n    <= 1'b1;
                    mlcd_wr_n    <= 1'b1;
                    mlcd_rd_n    <= 1'b1;
                    mlcd_data_oe <= 1'b0;
                end
                S_SETUP: begin
                    mlcd_cs_n <= 1'b0;
                    mlcd_wr_n <= 1'b1;
                    mlcd_rd_n <= 1'b1;
                    mlcd_rs   <= (cur_type != 2'b00);
                    if (cur_type == 2'b10) begin
                        mlcd_data_oe <= 1'b0;
                    end else begin
                        mlcd_data_oe <= 1'b1;
                        mlcd_data_o  <= cur_data;
                    end
                end
                S_WR_LO: mlcd_wr_n <= 1'b0;
                S_WR_HI: mlcd_wr_n <= 1'b1;
                S_RD_LO: begin
                    mlcd_rd_n    <= 1'b0;
                    mlcd_data_oe <= 1'b0;
                end
                S_RD_HI: begin
                    mlcd_rd_n <= 1'b1;
                    // The edge that releases rd_n is the capture edge.
                    if (!mlcd_rd_n) begin
                        rd_data  <= mlcd_data_i;
                        rd_valid <= 1'b1;
                    end
                end
                default: mlcd_cs_n <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_mlcd_8080_ctrl.sv
// tb/tb_mlcd_8080_ctrl.sv - self-checking bench for mlcd_8080_ctrl against a transaction-level bus model
module tb_mlcd_8080_ctrl;
    localparam int DW    = 16;
    localparam int LEN_W = 17;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_type = '0;
    logic [DW-1:0]    req_data = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic             rd_valid;
    logic [DW-1:0]    rd_data;
    logic             busy;
    logic             mlcd_cs_n, mlcd_wr_n, mlcd_rd_n, mlcd_rs, mlcd_data_oe;
    logic [DW-1:0]    mlcd_data_o;
    logic [DW-1:0]    mlcd_data_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] rd_tab [64];
    int            rd_idx = 0;
    int            rd_valid_cnt = 0;
    assign mlcd_data_i = rd_tab[rd_idx];

    logic [DW:0] obs_wr[$];
    logic [DW:0] exp_wr[$];
    int wr_fall_cyc[$];
    int wr_low_len[$];
    int cs_low_len[$];
    int rd_low_len[$];
    int cs_run = 0, wr_run = 0, rd_run = 0;
    int cs_fall_cyc = 0, acc_cyc = 0, stalls = 0, n_reads = 0;
    logic prev_cs = 1'b1, prev_wr = 1'b1, prev_rd = 1'b1, prev_oe = 1'b0, oe_before_rd = 1'b1;

    mlcd_8080_ctrl #(
        .DW(DW), .FIFO_DEPTH(8), .LEN_W(LEN_W),
        .WR_LOW(2), .WR_HIGH(2), .RD_LOW(5), .RD_HIGH(5)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_data(req_data), .req_len(req_len),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .mlcd_cs_n(mlcd_cs_n), .mlcd_wr_n(mlcd_wr_n), .mlcd_rd_n(mlcd_rd_n),
        .mlcd_rs(mlcd_rs), .mlcd_data_o(mlcd_data_o), .mlcd_data_oe(mlcd_data_oe),
        .mlcd_data_i(mlcd_data_i)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    initial begin
        #600000;
        $display("FAIL watchdog: observed no completion, expected finish before timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus observer: records write beats, strobe widths and bus-protocol invariants.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (!mlcd_wr_n) begin
                check("wr_rd_exclusive", 32'(mlcd_rd_n), 32'd1);
                check("oe_during_wr", 32'(mlcd_data_oe), 32'd1);
                check("cs_during_wr", 32'(mlcd_cs_n), 32'd0);
            end
            if (!mlcd_rd_n) check("oe_during_rd", 32'(mlcd_data_oe), 32'd0);
            if (rd_valid) begin
                check("rd_data", 32'(rd_data), 32'(rd_tab[rd_idx]));
                rd_idx = (rd_idx + 1) % 64;
                rd_valid_cnt++;
            end
        end
        if (!mlcd_cs_n) cs_run++;
        else if (cs_run != 0) begin cs_low_len.push_back(cs_run); cs_run = 0; end
        if (!mlcd_wr_n) wr_run++;
        else if (wr_run != 0) begin wr_low_len.push_back(wr_run); wr_run = 0; end
        if (!mlcd_rd_n) rd_run++;
        else if (rd_run != 0) begin rd_low_len.push_back(rd_run); rd_run = 0; end
        if (prev_wr && !mlcd_wr_n) begin
            obs_wr.push_back({mlcd_rs, mlcd_data_o});
            wr_fall_cyc.push_back(cyc);
        end
        if (prev_rd && !mlcd_rd_n) oe_before_rd = prev_oe;
        if (prev_cs && !mlcd_cs_n) cs_fall_cyc = cyc;
        prev_cs = mlcd_cs_n;
        prev_wr = mlcd_wr_n;
        prev_rd = mlcd_rd_n;
        prev_oe = mlcd_data_oe;
    end

    // Called at a negedge; returns at the negedge following acceptance and updates the reference model.
    task automatic push_req(input logic [1:0] t, input logic [DW-1:0] d, input logic [LEN_W-1:0] l);
        int waitc = 0;
        req_type  = t;
        req_data  = d;
        req_len   = l;
        req_valid = 1'b1;
        while (!req_ready && waitc < 200) begin
            @(negedge sys_clk);
            waitc++;
        end
        if (!req_ready) begin
            check("push_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (waitc > 0) stalls++;
        @(negedge sys_clk);
        acc_cyc   = cyc;
        req_valid = 1'b0;
        case (t)
            2'b00: exp_wr.push_back({1'b0, d});
            2'b01: exp_wr.push_back({1'b1, d});
            2'b10: n_reads++;
            default: for (int i = 0; i < int'(l); i++) exp_wr.push_back({1'b1, d});
        endcase
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge sys_clk);
        while (busy && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic compare_and_clear(input string tag);
        check({tag, "_count"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
            check(tag, 32'(obs_wr[i]), 32'(exp_wr[i]));
        obs_wr.delete();
        exp_wr.delete();
        wr_fall_cyc.delete();
        wr_low_len.delete();
        cs_low_len.delete();
        rd_low_len.delete();
    endtask

    initial begin
        int base_reads, base_valid, n_snap;
        for (int i = 0; i < 64; i++) rd_tab[i] = DW'($urandom);

        repeat (3) @(negedge sys_clk);
        check("rst_cs_n", 32'(mlcd_cs_n), 32'd1);
        check("rst_wr_n", 32'(mlcd_wr_n), 32'd1);
        check("rst_rd_n", 32'(mlcd_rd_n), 32'd1);
        check("rst_rs", 32'(mlcd_rs), 32'd0);
        check("rst_data_o", 32'(mlcd_data_o), 32'd0);
        check("rst_oe", 32'(mlcd_data_oe), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        push_req(2'b00, 16'h002C, '0);
        wait_idle(100);
        check("t1_setup_latency", 32'(cs_fall_cyc - acc_cyc), 32'd2);
        check("t1_cs_runs", 32'(cs_low_len.size()), 32'd1);
        check("t1_cs_len", 32'(cs_low_len.size() > 0 ? cs_low_len[0] : -1), 32'd5);
        check("t1_wr_len", 32'(wr_low_len.size() > 0 ? wr_low_len[0] : -1), 32'd2);
        check("t1_idle_cs", 32'(mlcd_cs_n), 32'd1);
        check("t1_idle_oe", 32'(mlcd_data_oe), 32'd0);
        check("t1_hold_data", 32'(mlcd_data_o), 32'h002C);
        compare_and_clear("t1_beat");

        push_req(2'b00, 16'h002A, '0);
        push_req(2'b01, 16'h0000, '0);
        push_req(2'b01, 16'h00EF, '0);
        wait_idle(100);
        check("t2_cs_runs", 32'(cs_low_len.size()), 32'd1);
        check("t2_cs_len", 32'(cs_low_len.size() > 0 ? cs_low_len[0] : -1), 32'd15);
        compare_and_clear("t2_beat");

        push_req(2'b11, 16'hF800, LEN_W'(4));
        wait_idle(200);
        check("t3_pulses", 32'(wr_fall_cyc.size()), 32'd4);
        for (int i = 1; i < wr_fall_cyc.size(); i++)
            check("t3_spacing", 32'(wr_fall_cyc[i] - wr_fall_cyc[i-1]), 32'd4);
        for (int i = 0; i < wr_low_len.size(); i++)
            check("t3_wr_len", 32'(wr_low_len[i]), 32'd2);
        compare_and_clear("t3_beat");
        push_req(2'b11, 16'h1234, '0);
        wait_idle(100);
        check("t3_len0_no_pulse", 32'(obs_wr.size()), 32'd0);
        check("t3_len0_busy", 32'(busy), 32'd0);
        compare_and_clear("t3_len0");

        rd_tab[rd_idx] = 16'h9341;
        rd_valid_cnt = 0;
        push_req(2'b01, 16'h1234, '0);
        push_req(2'b10, '0, '0);
        wait_idle(100);
        check("t4_oe_before_rd", 32'(oe_before_rd), 32'd0);
        check("t4_rd_len", 32'(rd_low_len.size() > 0 ? rd_low_len[0] : -1), 32'd5);
        check("t4_rd_valid_cnt", 32'(rd_valid_cnt), 32'd1);
        check("t4_rd_data", 32'(rd_data), 32'h9341);
        compare_and_clear("t4_beat");

        for (int i = 0; i < 10; i++) push_req(2'b01, DW'(16'hA000 + i), '0);
        check("t5_ready_full", 32'(req_ready), 32'd0);
        wait_idle(200);
        compare_and_clear("t5_order");

        base_reads = n_reads;
        base_valid = rd_valid_cnt;
        for (int i = 0; i < 30; i++) begin
            push_req(2'($urandom_range(0, 3)), DW'($urandom), LEN_W'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        end
        wait_idle(3000);
        check("rand_reads", 32'(rd_valid_cnt - base_valid), 32'(n_reads - base_reads));
        compare_and_clear("rand_beat");

        push_req(2'b11, 16'h5555, LEN_W'(100));
        begin
            int n = 0;
            while (wr_fall_cyc.size() < 2 && n < 200) begin
                @(negedge sys_clk);
                n++;
            end
        end
        check("t6_fill_started", 32'(wr_fall_cyc.size() >= 2), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("t6_cs_n", 32'(mlcd_cs_n), 32'd1);
        check("t6_wr_n", 32'(mlcd_wr_n), 32'd1);
        check("t6_rd_n", 32'(mlcd_rd_n), 32'd1);
        check("t6_oe", 32'(mlcd_data_oe), 32'd0);
        check("t6_data_o", 32'(mlcd_data_o), 32'd0);
        check("t6_rs", 32'(mlcd_rs), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        n_snap = obs_wr.size();
        repeat (30) @(negedge sys_clk);
        check("t6_no_strobes", 32'(obs_wr.size()), 32'(n_snap));
        check("t6_idle_cs", 32'(mlcd_cs_n), 32'd1);
        check("t6_idle_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
